// File: rtl/burst_arbiter_pkg.sv
// Shared definitions for the BurstRAM arbiter and the cache blocks that sit on it.
// FSM state encoding plus the cache-line and beat-counter width helpers.
package burst_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    // One cache line is a whole burst: beat width times beats per burst.
    function automatic int line_width(input int beat_w, input int beat_count);
        return beat_w * beat_count;
    endfunction

    function automatic int cnt_width(input int beat_count);
        return (beat_count > 1) ? $clog2(beat_count) : 1;
    endfunction

endpackage

// File: rtl/burst_arbiter_rr.sv
// Two-way round-robin grant: on a tie the client not granted last wins.
// The last-grant flag resets to B so that client A wins the first tie.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    always_comb begin
        gnt_a = req_a & (~req_b | last_b);
        gnt_b = req_b & ~gnt_a;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b <= 1'b1;
        end else if (accept) begin
            last_b <= gnt_b;
        end
    end

endmodule

// File: rtl/burst_arbiter.sv
// Shares one BurstRAM port between a data-cache client (A, read/write) and an
// instruction-cache client (B, read only), moving whole cache lines as bursts.
module burst_arbiter
    import burst_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    localparam int LINE_W = line_width(RAM_BURST_DATA_BITWIDTH, RAM_BURST_DATA_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 a_req,
    input  logic                                 a_we,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        a_addr,
    input  logic [LINE_W-1:0]                    a_wr_data,
    output logic [LINE_W-1:0]                    a_rd_data,
    output logic                                 a_done,
    input  logic                                 b_req,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        b_addr,
    output logic [LINE_W-1:0]                    b_rd_data,
    output logic                                 b_done,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int BW    = RAM_BURST_DATA_BITWIDTH;
    localparam int CNT_W = cnt_width(RAM_BURST_DATA_COUNT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    state_t            state;
    logic              sel_b;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_next;
    logic              gnt_a;
    logic              gnt_b;
    logic              grant;
    logic              last_beat;
    logic              beat_in;

    assign grant     = (state == ST_IDLE) && (a_req || b_req) && !br_busy;
    assign next_cnt  = beat_cnt + CNT_W'(1);
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign beat_in   = br_rd_data_valid && ((state == ST_RD_WAIT) || (state == ST_RD_DATA));

    // Gated by br_busy in the same cycle so a late busy can never leak a command.
    assign br_cmd_en    = (state == ST_CMD) && !br_busy;
    assign br_data_mask = '0;

    always_comb begin
        line_next = line_buf;
        line_next[int'(beat_cnt) * BW +: BW] = br_rd_data;
    end

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_a  (a_req),
        .req_b  (b_req),
        .accept (grant),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    always_ff @(posedge clk) begin
        if (grant) begin
            wr_line <= a_wr_data;
        end
        if (beat_in) begin
            line_buf <= line_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sel_b      <= 1'b0;
            beat_cnt   <= '0;
            br_cmd     <= 1'b0;
            br_addr    <= '0;
            br_wr_data <= '0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            a_rd_data  <= '0;
            b_rd_data  <= '0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        sel_b      <= gnt_b;
                        br_cmd     <= gnt_a & a_we;
                        br_addr    <= gnt_b ? b_addr : a_addr;
                        br_wr_data <= a_wr_data[BW-1:0];
                        beat_cnt   <= '0;
                        state      <= ST_CMD;
                    end
                end
                ST_CMD, ST_WR_DATA: begin
                    if (state == ST_CMD && br_busy) begin
                        state <= ST_CMD;
                    end else if (state == ST_CMD && !br_cmd) begin
                        state <= ST_RD_WAIT;
                    end else if (last_beat) begin
                        state  <= ST_DONE;
                        a_done <= !sel_b;
                        b_done <= sel_b;
                    end else begin
                        br_wr_data <= wr_line[int'(next_cnt) * BW +: BW];
                        beat_cnt   <= next_cnt;
                        state      <= ST_WR_DATA;
                    end
                end
                ST_RD_WAIT, ST_RD_DATA: begin
                    // Counter only moves on valid beats, so gaps just stretch the burst.
                    if (br_rd_data_valid) begin
                        if (last_beat) begin
                            state  <= ST_DONE;
                            a_done <= !sel_b;
                            b_done <= sel_b;
                            if (sel_b) begin
                                b_rd_data <= line_next;
                            end else begin
                                a_rd_data <= line_next;
                            end
                        end else begin
                            beat_cnt <= next_cnt;
                            state    <= ST_RD_DATA;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_arbiter.sv
// Randomized bench for burst_arbiter: a BurstRAM responder plus a line-level
// memory model predict every command, beat, done pulse and returned line.
module tb_burst_arbiter;

    localparam int AW = 8;
    localparam int BW = 64;
    localparam int C  = 4;
    localparam int LW = BW * C;

    typedef logic [LW-1:0] line_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req;
    logic [AW-1:0] a_addr, b_addr;
    line_t         a_wr_data, a_rd_data, b_rd_data;
    logic          a_done, b_done;
    logic          br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [AW-1:0] br_addr;
    logic [BW-1:0] br_wr_data, br_rd_data;
    logic [BW/8-1:0] br_data_mask;

    burst_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wr_data        (a_wr_data),
        .a_rd_data        (a_rd_data),
        .a_done           (a_done),
        .b_req            (b_req),
        .b_addr           (b_addr),
        .b_rd_data        (b_rd_data),
        .b_done           (b_done),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input line_t got, input line_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line-level reference state
    line_t ram [256];
    line_t ref_mem [256];
    line_t exp_a_rd = '0;
    line_t exp_b_rd = '0;

    // Responder observations
    int            cmd_cnt = 0;
    int            cmd_cyc = 0;
    int            last_beat_cyc = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_dir = 1'b0;
    line_t         wr_seen = '0;
    int            pre_cfg [C];
    bit            rand_timing = 1'b0;
    bit            noise_en = 1'b0;

    function automatic line_t rnd_line();
        line_t r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_idle();
        br_rd_data_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        br_rd_data = {$urandom, $urandom};
    endtask

    task automatic collect_write();
        line_t l;
        bit    ab;
        ab = 1'b0;
        l = '0;
        l[BW-1:0] = br_wr_data;
        chk("br_data_mask", line_t'(br_data_mask), '0);
        for (int k = 1; k < C; k++) begin
            @(negedge clk);
            drive_idle();
            if (!rst) begin
                ab = 1'b1;
                break;
            end
            chk("cmd_en_in_burst", line_t'(br_cmd_en), '0);
            l[k*BW +: BW] = br_wr_data;
        end
        if (!ab) begin
            ram[cmd_addr] = l;
            wr_seen = l;
        end
    endtask

    task automatic serve_read();
        line_t l;
        int    pre;
        l = ram[cmd_addr];
        for (int k = 0; k < C; k++) begin
            if (rand_timing) pre = (k == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2));
            else pre = pre_cfg[k];
            repeat (pre) begin
                @(negedge clk);
                if (!rst) return;
                br_rd_data_valid = 1'b0;
                br_rd_data = {$urandom, $urandom};
            end
            @(negedge clk);
            if (!rst) return;
            br_rd_data_valid = 1'b1;
            br_rd_data = l[k*BW +: BW];
            last_beat_cyc = cyc;
        end
    endtask

    // BurstRAM responder
    initial begin
        br_rd_data_valid = 1'b0;
        br_rd_data = '0;
        forever begin
            @(negedge clk);
            drive_idle();
            if (rst && br_cmd_en) begin
                chk("cmd_en_while_busy", line_t'(br_busy), '0);
                cmd_cnt++;
                cmd_cyc  = cyc;
                cmd_addr = br_addr;
                cmd_dir  = br_cmd;
                if (br_cmd) collect_write();
                else serve_read();
            end
        end
    end

    // One client transaction; starts and ends just after a falling edge.
    task automatic txn(input bit is_b, input bit we, input logic [AW-1:0] addr,
                       input line_t wl, input int busy_len, input string nm);
        int    t0, c0, dcyc;
        bit    got;
        bit    is_wr;
        line_t exp_rd;
        got = 1'b0;
        is_wr = !is_b && we;
        exp_rd = ref_mem[addr];
        if (is_b) begin
            b_req = 1'b1;
            b_addr = addr;
        end else begin
            a_req = 1'b1;
            a_we = we;
            a_addr = addr;
            a_wr_data = wl;
        end
        t0 = cyc;
        c0 = cmd_cnt;
        if (busy_len > 0) begin
            @(posedge clk);
            #1 br_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 br_busy = 1'b0;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (is_b ? b_done : a_done) got = 1'b1;
        end
        dcyc = cyc;
        chk({nm, "_done_seen"}, line_t'(got), line_t'(1));
        chk({nm, "_other_done"}, line_t'(is_b ? a_done : b_done), '0);
        if (is_b) b_req = 1'b0;
        else a_req = 1'b0;
        chk({nm, "_cmd_count"}, line_t'(cmd_cnt - c0), line_t'(1));
        chk({nm, "_cmd_addr"}, line_t'(cmd_addr), line_t'(addr));
        chk({nm, "_cmd_dir"}, line_t'(cmd_dir), line_t'(is_wr));
        chk({nm, "_cmd_lat"}, line_t'(cmd_cyc - t0), line_t'(1 + busy_len));
        if (is_wr) begin
            chk({nm, "_wr_line"}, wr_seen, wl);
            chk({nm, "_wr_lat"}, line_t'(dcyc - t0), line_t'(C + 1 + busy_len));
            ref_mem[addr] = wl;
        end else begin
            chk({nm, "_rd_lat"}, line_t'(dcyc - last_beat_cyc), line_t'(1));
            if (is_b) exp_b_rd = exp_rd;
            else exp_a_rd = exp_rd;
        end
        chk({nm, "_a_rd_data"}, a_rd_data, exp_a_rd);
        chk({nm, "_b_rd_data"}, b_rd_data, exp_b_rd);
        @(negedge clk);
        chk({nm, "_done_pulse"}, line_t'({a_done, b_done}), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t         x, y;
        int            n;
        int            q [$];
        bit            dn;
        bit            ib, w;
        logic [AW-1:0] ad;
        int            bl;

        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wr_data = '0;
        b_req = 1'b0; b_addr = '0;
        br_busy = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = rnd_line();
            ref_mem[i] = ram[i];
        end
        ram[8'h40] = {64'hD, 64'hC, 64'hB, 64'hA};
        ref_mem[8'h40] = ram[8'h40];

        repeat (3) @(negedge clk);
        chk("rst_ctrl", line_t'({br_cmd_en, br_cmd, br_addr, a_done, b_done, br_data_mask}), '0);
        chk("rst_wr_data", line_t'(br_wr_data), '0);
        chk("rst_a_rd_data", a_rd_data, '0);
        chk("rst_b_rd_data", b_rd_data, '0);
        rst = 1'b1;
        @(negedge clk);

        // Single write, beat k = k+1
        txn(1'b0, 1'b1, 8'h12, {64'd4, 64'd3, 64'd2, 64'd1}, 0, "wr_single");
        chk("wr_single_ram", ram[8'h12], {64'd4, 64'd3, 64'd2, 64'd1});

        // Single read, first beat three cycles after the command
        pre_cfg = '{2, 0, 0, 0};
        txn(1'b1, 1'b0, 8'h40, '0, 0, "rd_single");
        chk("rd_single_line", b_rd_data, {64'hD, 64'hC, 64'hB, 64'hA});

        // Two-cycle valid gap after beat 1
        pre_cfg = '{1, 0, 2, 0};
        txn(1'b0, 1'b0, 8'h12, '0, 0, "rd_gap");
        chk("rd_gap_line", a_rd_data, {64'd4, 64'd3, 64'd2, 64'd1});

        // Busy for five cycles right after grant
        txn(1'b0, 1'b1, 8'h33, rnd_line(), 5, "wr_busy");

        // Reset during write beat 2
        y = rnd_line();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wr_data = y;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        a_req = 1'b0;
        #1;
        chk("midrst_ctrl", line_t'({br_cmd_en, br_cmd, br_addr, a_done, b_done}), '0);
        chk("midrst_wr_data", line_t'(br_wr_data), '0);
        chk("midrst_a_rd_data", a_rd_data, '0);
        chk("midrst_b_rd_data", b_rd_data, '0);
        exp_a_rd = '0;
        exp_b_rd = '0;
        dn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            dn = dn | a_done | b_done;
        end
        chk("midrst_no_done", line_t'(dn), '0);
        rst = 1'b1;
        rand_timing = 1'b1;
        txn(1'b1, 1'b0, 8'h40, '0, 0, "rd_after_rst");
        chk("rd_after_rst_line", b_rd_data, {64'hD, 64'hC, 64'hB, 64'hA});

        // Both clients held requesting for four transactions
        x = rnd_line();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wr_data = x;
        b_req = 1'b1; b_addr = 8'h20;
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            @(negedge clk);
            if (a_done) begin
                q.push_back(0);
                ref_mem[8'h20] = x;
                n++;
            end
            if (b_done) begin
                q.push_back(1);
                exp_b_rd = ref_mem[8'h20];
                chk("rr_b_line", b_rd_data, exp_b_rd);
                n++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("rr_count", line_t'(n), line_t'(4));
        for (int i = 0; i < q.size(); i++) chk("rr_order", line_t'(q[i]), line_t'(i % 2));
        @(negedge clk);

        // Random traffic with random read timing and stray valids
        noise_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            ib = 1'($urandom_range(0, 1));
            w  = ib ? 1'b0 : 1'($urandom_range(0, 1));
            ad = AW'($urandom_range(0, 7));
            bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            txn(ib, w, ad, rnd_line(), bl, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 SHALL have parameter RAM_DEPTH_BITWIDTH, default 8: BurstRAM address width.
REQ-002 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64: width of one burst beat.
REQ-003 SHALL have parameter RAM_BURST_DATA_COUNT, default 4: beats per burst; one cache line is LINE_W = RAM_BURST_DATA_BITWIDTH*RAM_BURST_DATA_COUNT bits.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports a_req in 1, a_we in 1, a_addr in RAM_DEPTH_BITWIDTH, a_wr_data in LINE_W, a_rd_data out LINE_W, a_done out 1: data-cache line read/write client.
REQ-007 SHALL have ports b_req in 1, b_addr in RAM_DEPTH_BITWIDTH, b_rd_data out LINE_W, b_done out 1: instruction-cache line-fill client, read only.
REQ-008 SHALL have ports br_cmd out 1 (1=write, 0=read), br_cmd_en out 1, br_addr out RAM_DEPTH_BITWIDTH, br_wr_data out RAM_BURST_DATA_BITWIDTH, br_data_mask out RAM_BURST_DATA_BITWIDTH/8, br_rd_data in RAM_BURST_DATA_BITWIDTH, br_rd_data_valid in 1, br_busy in 1.

Function
REQ-009 SHALL implement FSM states IDLE, CMD, WR_DATA, RD_WAIT, RD_DATA, DONE.
REQ-010 IDLE: with any request and br_busy low, SHALL grant one client, latch its address, direction and write line, and enter CMD next cycle.
REQ-011 Arbitration SHALL be round-robin: on simultaneous a_req and b_req, grant the client not granted last; after reset A has priority.
REQ-012 CMD: SHALL drive br_cmd_en=1 for exactly one cycle with br_addr = latched address and br_cmd = latched direction.
REQ-013 Write: beat 0 (line bits [RAM_BURST_DATA_BITWIDTH-1:0]) SHALL be on br_wr_data in the CMD cycle; beats 1..COUNT-1 SHALL follow in consecutive WR_DATA cycles, ascending order; br_data_mask SHALL be all zeros (all bytes written).
REQ-014 Read: after CMD, SHALL wait in RD_WAIT for br_rd_data_valid, then capture COUNT consecutive valid beats into a line buffer at ascending slices, beat 0 to the lowest slice.
REQ-015 If br_rd_data_valid drops mid-burst, SHALL hold the beat counter and resume on the next valid beat; no beat lost or duplicated.
REQ-016 DONE: SHALL pulse the granted client's done for exactly one cycle, with a_rd_data/b_rd_data valid in that cycle and held until that client's next completed read; then return to IDLE.
REQ-017 Latency: a write SHALL complete with done COUNT+1 cycles after leaving IDLE; a read SHALL complete with done one cycle after the last valid beat.
REQ-018 A requester SHALL hold req, addr, we and wr_data stable until its done; req changes of the non-granted client SHALL not disturb the transaction in flight.
REQ-019 A client whose req is still high in the DONE cycle SHALL be treated as a new request; no back-to-back re-grant to the same client while the other is requesting.
REQ-020 br_cmd_en SHALL never be asserted while br_busy is high; when br_busy rises between grant and CMD, SHALL stall in CMD with br_cmd_en=0 until it falls.
REQ-021 br_rd_data_valid outside RD_WAIT/RD_DATA SHALL be ignored.

Reset
REQ-022 On rst low, asynchronously: state=IDLE, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=0, a_done=0, b_done=0, a_rd_data=0, b_rd_data=0, beat counter=0, last-grant=B (so A wins first tie).
REQ-023 Reset mid-burst SHALL abandon the transaction; no done pulse is produced for it.

Structure
REQ-024 State encodings and the LINE_W derivation SHALL reside in the shared package used by the RAM/cache blocks.
REQ-025 Round-robin grant logic MAY be one sub-module, rr_arbiter2; line buffer and beat counter stay in burst_arbiter.

Verification
REQ-026 Single write: a_req, a_we=1, a_addr=0x12, line=0x...04_03_02_01 (beat k = k+1) -> one br_cmd_en with br_cmd=1, br_addr=0x12, beats 1,2,3,4 in consecutive cycles, a_done 5 cycles after grant.
REQ-027 Single read: b_req, b_addr=0x40, model returns beats 0xA..0xD after 3-cycle latency -> b_rd_data = {0xD,0xC,0xB,0xA}, b_done one cycle after last beat.
REQ-028 Simultaneous a_req and b_req held high for 4 transactions -> grant order A,B,A,B.
REQ-029 br_busy high for 5 cycles after grant -> br_cmd_en stays 0 during busy, asserts once on the first non-busy cycle.
REQ-030 br_rd_data_valid gap of 2 cycles after beat 1 -> line still assembled correctly, done one cycle after beat 3.
REQ-031 rst asserted during WR_DATA beat 2 -> all outputs zero immediately, no done; subsequent read of same address completes normally.
